// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the fetch/decode slice: opcodes, canonical NOP,
// fetch FSM state encodings and a PC alignment helper.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_WAIT = 2'd1;
  localparam fetch_state_t S_FULL = 2'd2;
  localparam fetch_state_t S_DROP = 2'd3;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_instr_fields.sv
// Combinational RV32I field slicer; shared between fetch output and decode.
module instr_fields (
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

endmodule

// File: rtl/if_stage.sv
// RV32I fetch stage: single-outstanding word fetch, one-entry output buffer
// plus one holding slot, and redirect with wrong-path squashing.
module if_stage
  import rv32i_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2
);

  fetch_state_t    state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic            id_valid_r, id_valid_s;
  logic [XLEN-1:0] id_pc_r, id_pc_s;
  logic [XLEN-1:0] id_instr_r, id_instr_s;
  logic [XLEN-1:0] hold_pc_r, hold_pc_s;
  logic [XLEN-1:0] hold_instr_r, hold_instr_s;
  logic            req_s;
  logic            drain_s;
  logic            outstanding_s;

  // Next-state logic: normal fetch flow first, redirect overrides afterwards.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    id_pc_s      = id_pc_r;
    id_instr_s   = id_instr_r;
    hold_pc_s    = hold_pc_r;
    hold_instr_s = hold_instr_r;
    req_s        = 1'b0;
    drain_s      = id_valid_r && id_ready;

    if (drain_s) begin
      id_valid_s = 1'b0;
    end else begin
      id_valid_s = id_valid_r;
    end

    case (state_r)
      S_REQ: begin
        req_s = !redirect_valid;
        if (!redirect_valid) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pc_s = pc_r + 32'd4;
          if (!id_valid_r || id_ready) begin
            id_valid_s = 1'b1;
            id_instr_s = imem_rdata;
            id_pc_s    = pc_r;
            state_s    = S_REQ;
          end else begin
            // Buffer is busy; park the word so the presented entry stays stable.
            hold_instr_s = imem_rdata;
            hold_pc_s    = pc_r;
            state_s      = S_FULL;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FULL: begin
        if (id_ready) begin
          id_valid_s = 1'b1;
          id_instr_s = hold_instr_r;
          id_pc_s    = hold_pc_r;
          state_s    = S_REQ;
        end else begin
          state_s = S_FULL;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_s = S_REQ;
        end else begin
          state_s = S_DROP;
        end
      end
      default: begin
        state_s = S_REQ;
      end
    endcase

    // A fetch still in flight after a redirect must be absorbed in S_DROP.
    outstanding_s = ((state_r == S_WAIT) || (state_r == S_DROP)) && !imem_rvalid;

    if (redirect_valid) begin
      pc_s       = align_pc(redirect_pc);
      id_valid_s = 1'b0;
      id_pc_s    = id_pc_r;
      id_instr_s = id_instr_r;
      if (outstanding_s) begin
        state_s = S_DROP;
      end else begin
        state_s = S_REQ;
      end
    end else begin
      outstanding_s = outstanding_s;
    end
  end

  // State, PC and output buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_REQ;
      pc_r         <= RESET_PC;
      id_valid_r   <= 1'b0;
      id_pc_r      <= RESET_PC;
      id_instr_r   <= NOP_INSTR;
      hold_pc_r    <= RESET_PC;
      hold_instr_r <= NOP_INSTR;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      id_valid_r   <= id_valid_s;
      id_pc_r      <= id_pc_s;
      id_instr_r   <= id_instr_s;
      hold_pc_r    <= hold_pc_s;
      hold_instr_r <= hold_instr_s;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_r;
  assign id_valid  = id_valid_r;
  assign id_pc     = id_pc_r;
  assign id_instr  = id_instr_r;

  instr_fields u_fields (
    .instr  (id_instr_r),
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory responder with random latency and
// an in-order PC-stream scoreboard that tracks redirects.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_pc;
  bit          mem_pending;
  int          mem_delay;
  logic [31:0] mem_addr;
  bit          last_rvalid;
  bit          prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] req_log[$];
  logic [31:0] acc_log[$];
  logic [6:0]  opc_log[$];

  if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0033;
      32'h0000_0004: return 32'h0020_8063;
      32'h0000_0008: return 32'h0000_006F;
      default:       return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endcase
  endfunction

  // One clock cycle, entered and left at posedge+1.
  task automatic run_cycle(input bit rdy, input bit redir, input logic [31:0] tgt, input int lat);
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (mem_pending && mem_delay == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
      mem_pending = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (mem_pending) mem_delay--;
    end
    last_rvalid = imem_rvalid;
    #1;
    if (prev_hold) begin
      tests++;
      if (id_valid !== 1'b1 || id_pc !== prev_pc || id_instr !== prev_instr)
        $display("FAIL hold_stable: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                 id_valid, id_pc, id_instr, prev_pc, prev_instr);
      if (id_valid !== 1'b1 || id_pc !== prev_pc || id_instr !== prev_instr) fails++;
    end
    if (id_valid === 1'b1 && rdy) begin
      tests++;
      if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc) ||
          {funct7, rs2, rs1, funct3, rd, opcode} !== mem_word(exp_pc)) begin
        fails++;
        $display("FAIL accept: pc=%h instr=%h fields=%h, required pc=%h instr=%h",
                 id_pc, id_instr, {funct7, rs2, rs1, funct3, rd, opcode}, exp_pc, mem_word(exp_pc));
      end
      acc_log.push_back(id_pc);
      opc_log.push_back(opcode);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    if (imem_req === 1'b1) begin
      tests++;
      if (mem_pending || redir) begin
        fails++;
        $display("FAIL req_legal: req at %h with pending=%0d redirect=%0d, required neither",
                 imem_addr, mem_pending, redir);
      end
      req_log.push_back(imem_addr);
      mem_pending = 1'b1;
      mem_addr    = imem_addr;
      mem_delay   = lat;
    end
    prev_hold  = (id_valid === 1'b1) && !rdy && !redir;
    prev_pc    = id_pc;
    prev_instr = id_instr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    mem_pending = 1'b0; prev_hold = 1'b0; exp_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (id_valid !== 1'b0 || opcode !== 7'b0010011 || id_pc !== 32'h0 || id_instr !== 32'h0000_0013) begin
      fails++;
      $display("FAIL reset_vals: valid=%b opcode=%b pc=%h instr=%h, required 0/0010011/0/00000013",
               id_valid, opcode, id_pc, id_instr);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_req: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
    #1;
    @(posedge clk);
    #1;
    // Re-enter cleanly: one extra cycle elapsed, restart the pipe with a short reset.
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [6:0] exp_opc[3];
    exp_opc[0] = 7'b0110011; exp_opc[1] = 7'b1100011; exp_opc[2] = 7'b1101111;
    req_log.delete(); acc_log.delete(); opc_log.delete();
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b1, 1'b0, 32'h0, 0);
      if (last_rvalid) begin
        tests++;
        if (id_valid !== 1'b1) begin
          fails++;
          $display("FAIL latency: id_valid=%b one cycle after rvalid, required 1", id_valid);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (req_log.size() <= i || acc_log.size() <= i || opc_log.size() <= i) begin
        fails++;
        $display("FAIL basic_count: only %0d req / %0d acc, required > %0d", req_log.size(), acc_log.size(), i);
      end else if (req_log[i] !== 32'(4 * i) || acc_log[i] !== 32'(4 * i) || opc_log[i] !== exp_opc[i]) begin
        fails++;
        $display("FAIL basic_seq%0d: req=%h pc=%h opcode=%b, required %h/%h/%b",
                 i, req_log[i], acc_log[i], opc_log[i], 32'(4 * i), 32'(4 * i), exp_opc[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    int req0;
    int acc0;
    logic [31:0] held_pc;
    while (id_valid !== 1'b1 && guard < 20) begin
      run_cycle(1'b1, 1'b0, 32'h0, 0);
      guard++;
    end
    tests++;
    if (id_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_timeout: id_valid never rose within 20 cycles");
    end
    held_pc = id_pc;
    req0 = req_log.size();
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 32'h0, 0);
    tests++;
    if (req_log.size() - req0 > 1 || id_pc !== held_pc || id_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_stall: extra reqs=%0d pc=%h valid=%b, required <=1/%h/1",
               req_log.size() - req0, id_pc, id_valid, held_pc);
    end
    acc0 = acc_log.size();
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, 32'h0, 0);
    tests++;
    if (acc_log.size() - acc0 < 5 || acc_log[acc0] !== held_pc) begin
      fails++;
      $display("FAIL bp_release: accepted=%0d first=%h, required >=5 starting %h",
               acc_log.size() - acc0, acc_log[acc0], held_pc);
    end
  endtask

  task automatic test_redirect(input bit with_rvalid, input logic [31:0] tgt);
    int guard = 0;
    int ridx;
    int aidx;
    while (!(mem_pending && ((mem_delay == 0) == with_rvalid)) && guard < 30) begin
      run_cycle(1'b1, 1'b0, 32'h0, 1);
      guard++;
    end
    ridx = req_log.size();
    aidx = acc_log.size();
    run_cycle(1'b1, 1'b1, tgt, 1);
    guard = 0;
    while (acc_log.size() <= aidx && guard < 30) begin
      run_cycle(1'b1, 1'b0, 32'h0, 1);
      guard++;
    end
    tests++;
    if (req_log.size() <= ridx || acc_log.size() <= aidx) begin
      fails++;
      $display("FAIL redir_timeout: no request/accept after redirect to %h", tgt);
    end else if (req_log[ridx] !== {tgt[31:2], 2'b00} || acc_log[aidx] !== {tgt[31:2], 2'b00}) begin
      fails++;
      $display("FAIL redir_target: req=%h pc=%h, required %h", req_log[ridx], acc_log[aidx],
               {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_reset_in_wait();
    int guard = 0;
    int ridx;
    int aidx;
    while (!(mem_pending && mem_delay > 0) && guard < 30) begin
      run_cycle(1'b0, 1'b0, 32'h0, 2);
      guard++;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0000_0013 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_async: valid=%b pc=%h instr=%h addr=%h, required 0/0/00000013/0",
               id_valid, id_pc, id_instr, imem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_hold = 1'b0;
    exp_pc = 32'h0;
    // Stale response from before reset lands in the first cycle and must be ignored.
    mem_pending = 1'b1; mem_delay = 0; mem_addr = 32'h0000_0444;
    ridx = req_log.size();
    aidx = acc_log.size();
    while (acc_log.size() <= aidx + 1 && guard < 60) begin
      run_cycle(1'b1, 1'b0, 32'h0, 0);
      guard++;
    end
    tests++;
    if (req_log.size() <= ridx || acc_log.size() <= aidx + 1 ||
        req_log[ridx] !== 32'h0 || acc_log[aidx] !== 32'h0 || acc_log[aidx + 1] !== 32'h4) begin
      fails++;
      $display("FAIL rst_restart: fetch did not restart cleanly at 00000000 (reqs=%0d accs=%0d)",
               req_log.size() - ridx, acc_log.size() - aidx);
    end
  endtask

  task automatic test_random();
    int acc0 = acc_log.size();
    bit redir;
    logic [31:0] tgt;
    for (int i = 0; i < 1500; i++) begin
      redir = ($urandom_range(99, 0) < 5);
      tgt   = $urandom & 32'h0000_0FFF;
      run_cycle(($urandom_range(99, 0) < 60), redir, tgt, $urandom_range(3, 0));
    end
    tests++;
    if (acc_log.size() - acc0 < 100) begin
      fails++;
      $display("FAIL random_progress: %0d accepted, required >= 100", acc_log.size() - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect(1'b0, 32'h0000_0100);
    test_redirect(1'b1, 32'h0000_0203);
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
